// File: rtl/y_packer.sv
// Serial-to-parallel bit packer: collects Y_data bits LSB-first into WIDTH-bit
// words (or flushed partial words) and queues them in a first-word-fall-through FIFO.
module y_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           Y_data,
    input  logic                           Y_enable,
    output logic                           Y_ready,
    input  logic                           flush,
    output logic [WIDTH-1:0]               out_data,
    output logic [$clog2(WIDTH+1)-1:0]     out_len,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int LW  = $clog2(WIDTH + 1);
    localparam int CW  = $clog2(WIDTH);
    localparam int PW  = $clog2(DEPTH);
    localparam int LVW = $clog2(DEPTH + 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("y_packer: WIDTH out of range");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("y_packer: DEPTH must be a power of two in 2..16");
    end

    logic [WIDTH-1:0] partial;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [LW-1:0]    mem_len  [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LVW-1:0]   level_q;

    logic             accept;
    logic             pop;
    logic             full_word;
    logic             flush_push;
    logic             push;
    logic [LW-1:0]    k;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] word_next;
    logic [LW-1:0]    push_len;

    // Y_ready depends only on the registered occupancy, never on out_ready or flush.
    assign Y_ready   = (level_q < LVW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign level     = level_q;

    assign accept = Y_enable && Y_ready;
    assign pop    = out_valid && out_ready;

    // partial keeps zeros above cnt, so OR-ing the new bit in yields the padded word.
    always_comb begin
        bit_mask  = '0;
        if (accept && Y_data) begin
            bit_mask = WIDTH'(1) << cnt;
        end
        word_next = partial | bit_mask;
        k         = LW'(cnt) + LW'(accept);
        full_word = accept && (cnt == CW'(WIDTH - 1));
        flush_push = flush && Y_ready && !full_word && (k != '0);
        push      = full_word || flush_push;
        push_len  = full_word ? LW'(WIDTH) : k;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            partial <= '0;
            cnt     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                partial <= '0;
                cnt     <= '0;
            end else if (accept) begin
                partial <= word_next;
                cnt     <= cnt + CW'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({push, pop})
                2'b10:   level_q <= level_q + LVW'(1);
                2'b01:   level_q <= level_q - LVW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem_data[wr_ptr] <= word_next;
            mem_len[wr_ptr]  <= push_len;
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_len  = out_valid ? mem_len[rd_ptr]  : '0;

endmodule

// File: tb/tb_y_packer.sv
// Directed bench for y_packer (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_y_packer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       Y_data;
    logic       Y_enable;
    logic       Y_ready;
    logic       flush;
    logic [7:0] out_data;
    logic [3:0] out_len;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    y_packer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Y_data    (Y_data),
        .Y_enable  (Y_enable),
        .Y_ready   (Y_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic d, input logic fl, input logic ordy);
        Y_enable  = en;
        Y_data    = d;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b1, b[i], 1'b0, ordy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] exp_words [5];
        int acc;
        int rem;
        int pops;
        logic en;
        logic d;

        reset_n = 1'b0; Y_enable = 1'b0; Y_data = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_len", out_len, 0);
        reset_n = 1'b1;
        step(0, 0, 0, 0);
        chk("rst_ready", Y_ready, 1);

        // 1,0,1,1,0,0,0,1 LSB-first -> 0x8D, visible one cycle, then popped
        b = 8'h8D;
        for (int i = 0; i < 8; i++) begin
            step(1, b[i], 0, 1);
            if (i < 7) chk("w8d_early_valid", out_valid, 0);
        end
        chk("w8d_valid", out_valid, 1);
        chk("w8d_data", out_data, 8'h8D);
        chk("w8d_len", out_len, 8);
        step(0, 0, 0, 1);
        chk("w8d_valid_one_cycle", out_valid, 0);
        chk("w8d_level", level, 0);

        // three ones then flush -> 0x07 len 3
        send_bits(8'h07, 3, 0);
        step(0, 0, 1, 0);
        chk("flush3_valid", out_valid, 1);
        chk("flush3_data", out_data, 8'h07);
        chk("flush3_len", out_len, 3);
        chk("flush3_level", level, 1);
        step(0, 0, 0, 1);
        chk("flush3_pop_level", level, 0);

        // fresh word from bit 0, with ignored Y_data=1 on idle cycles -> 0xAA
        b = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            step(1, b[i], 0, 0);
            step(0, 1, 0, 0);
        end
        chk("fresh_data", out_data, 8'hAA);
        chk("fresh_len", out_len, 8);
        chk("fresh_level", level, 1);
        step(0, 0, 0, 1);

        // flush with nothing collected is a no-op
        step(0, 0, 1, 0);
        chk("flush0_valid", out_valid, 0);
        chk("flush0_level", level, 0);

        // flush together with an accepted bit: k=2 -> 0x03 len 2
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("flush_samecyc_data", out_data, 8'h03);
        chk("flush_samecyc_len", out_len, 2);
        chk("flush_samecyc_level", level, 1);
        step(0, 0, 0, 1);

        // flush on the 8th bit: only the full word is pushed
        b = 8'hB6;
        send_bits(b, 7, 0);
        step(1, b[7], 1, 0);
        chk("flush_full_data", out_data, 8'hB6);
        chk("flush_full_len", out_len, 8);
        chk("flush_full_level", level, 1);
        step(0, 0, 0, 1);
        chk("flush_full_no_extra", level, 0);

        // 40 ones into a stalled FIFO: only 32 accepted
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (Y_ready) acc++;
            step(1, 1, 0, 0);
        end
        chk("ones_accepted", acc, 32);
        chk("ones_level", level, 4);
        chk("ones_ready", Y_ready, 0);
        pops = 0;
        rem  = 8;
        chk("ones_pop_cycle_ready", Y_ready, 0);
        chk("ones_word", out_data, 8'hFF);
        pops++;
        step(1, 1, 0, 1);
        chk("ones_ready_after_pop", Y_ready, 1);
        chk("ones_level_after_pop", level, 3);
        for (int c = 0; c < 40 && pops < 5; c++) begin
            if (out_valid) begin
                chk("ones_word", out_data, 8'hFF);
                chk("ones_len", out_len, 8);
                pops++;
            end
            en = (rem > 0);
            if (Y_ready && en) rem--;
            step(en, 1, 0, 1);
        end
        chk("ones_pops", pops, 5);
        chk("ones_rem", rem, 0);
        chk("ones_drained", level, 0);

        // full FIFO of distinct words, drained while Y_enable held
        send_bits(8'h11, 8, 0);
        send_bits(8'h22, 8, 0);
        send_bits(8'h33, 8, 0);
        send_bits(8'h44, 8, 0);
        chk("order_full_level", level, 4);
        exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33;
        exp_words[3] = 8'h44; exp_words[4] = 8'h55;
        b    = 8'h55;
        rem  = 8;
        pops = 0;
        for (int c = 0; c < 40 && pops < 5; c++) begin
            if (c == 0) chk("order_ready_pop_cycle", Y_ready, 0);
            if (c == 1) chk("order_ready_next", Y_ready, 1);
            if (c < 4) chk("order_one_pop_per_cycle", out_valid, 1);
            if (out_valid) begin
                chk("order_word", out_data, exp_words[pops]);
                pops++;
            end
            en = (rem > 0);
            d  = en ? b[8 - rem] : 1'b0;
            if (Y_ready && en) rem--;
            step(en, d, 0, 1);
        end
        chk("order_pops", pops, 5);
        chk("order_drained", level, 0);

        // reset mid-operation with 2 queued words and 5 pending bits
        send_bits(8'h12, 8, 0);
        send_bits(8'h34, 8, 0);
        send_bits(8'h1F, 5, 0);
        chk("midrst_level_before", level, 2);
        reset_n = 1'b0;
        step(1, 1, 1, 1);
        chk("midrst_level", level, 0);
        chk("midrst_valid", out_valid, 0);
        reset_n = 1'b1;
        send_bits(8'hC3, 8, 0);
        chk("midrst_data", out_data, 8'hC3);
        chk("midrst_len", out_len, 8);
        chk("midrst_level_after", level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
